router_out_ctrl: RTL and testbench



---
 rtl/router_pkg.sv | 35 +++
 rtl/router_out_skid.sv | 50 +++++
 rtl/router_out_ctrl.sv | 161 ++++++++++++++++
 tb/tb_router_out_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Router output path: header layout, FSM states
// and the skid buffer entry format.
package router_pkg;

  localparam int BYTE_W      = 8;
  localparam int LEN_MSB     = 7;
  localparam int LEN_LSB     = 2;
  localparam int ADDR_MSB    = 1;
  localparam int ADDR_LSB    = 0;
  localparam int LEN_W       = 6;
  localparam int TIMEOUT_DEF = 30;

  typedef enum logic [1:0] {
    IDLE,
    HDR_WAIT,
    BODY,
    DRAIN
  } out_state_t;

  typedef struct packed {
    logic              perr;
    logic              eop;
    logic              sop;
    logic [BYTE_W-1:0] data;
  } skid_ent_t;

  // FIFO reads still owed after the header:
  // the payload bytes plus the parity byte.
  function automatic logic [LEN_W:0] pkt_remaining(
    input logic [BYTE_W-1:0] hdr
  );
    return {1'b0, hdr[LEN_MSB:LEN_LSB]} + 7'd1;
  endfunction

endpackage

// File: rtl/router_out_skid.sv
// Two-entry skid buffer between the FIFO read
// pipe and the output port; head drives the port.
module router_out_skid
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  skid_ent_t  din,
  output logic [1:0] count,
  output skid_ent_t  head
);

  skid_ent_t mem [2];
  logic      do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign head   = mem[0];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count  <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          mem[count[0]] <= din;
          count         <= count + 2'd1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            mem[0] <= din;
          end else begin
            mem[0] <= mem[1];
            mem[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/router_out_ctrl.sv
// Drains one router_fifo queue to an output port,
// framing sop/eop, checking parity, flushing on stall.
module router_out_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int DW      = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_read_enb,
  output logic          soft_reset_out,
  input  logic          ready_in,
  output logic          vld_out,
  output logic [DW-1:0] data_out,
  output logic          sop_out,
  output logic          eop_out,
  output logic          parity_err,
  output logic [1:0]    hdr_addr,
  output logic          busy
);

  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_MAX =
    SW'(TIMEOUT - 1);

  out_state_t     state;
  logic [LEN_W:0] remaining;
  logic [DW-1:0]  parity_acc;
  logic           pend;
  logic           pend_last;
  logic           hold_idle;
  logic [SW-1:0]  stall_cnt;

  logic [1:0] skid_cnt;
  skid_ent_t  head;
  skid_ent_t  push_ent;
  logic       push;
  logic       xfer;
  logic       stall;
  logic       timeout;
  logic       arrive;
  logic       allow;
  logic       drain_ok;
  logic [2:0] occ;

  assign xfer     = vld_out && ready_in;
  assign stall    = vld_out && !ready_in;
  assign timeout  = stall && (stall_cnt == STALL_MAX);
  assign arrive   = pend && !timeout;
  assign drain_ok = (state == DRAIN) &&
                    (skid_cnt == 2'd0);
  assign occ = {1'b0, skid_cnt} + {2'b0, pend}
             - {2'b0, xfer};

  always_comb begin
    allow = 1'b0;
    unique case (1'b1)
      state == IDLE: allow = !hold_idle;
      state == BODY: allow = remaining != '0;
      drain_ok:      allow = 1'b1;
      default:       allow = 1'b0;
    endcase
  end

  assign fifo_read_enb = allow && !fifo_empty &&
                         (occ < 3'd2) &&
                         !timeout && !reset;
  assign soft_reset_out = timeout && !reset;

  always_comb begin
    push_ent = '0;
    push     = 1'b0;
    if (arrive && state == HDR_WAIT) begin
      push     = 1'b1;
      push_ent = '{perr: 1'b0, eop: 1'b0,
                   sop: 1'b1, data: fifo_data};
    end else if (arrive && state == BODY) begin
      push     = 1'b1;
      push_ent = '{perr: pend_last &&
                         (parity_acc != fifo_data),
                   eop: pend_last, sop: 1'b0,
                   data: fifo_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      parity_acc <= '0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
      hold_idle  <= 1'b0;
      stall_cnt  <= '0;
      hdr_addr   <= '0;
    end else if (timeout) begin
      state     <= IDLE;
      remaining <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      hold_idle <= 1'b1;
      stall_cnt <= '0;
    end else begin
      pend      <= fifo_read_enb;
      pend_last <= fifo_read_enb &&
                   (state == BODY) &&
                   (remaining == 7'd1);
      hold_idle <= 1'b0;
      stall_cnt <= stall ? stall_cnt + SW'(1) : '0;
      unique case (state)
        IDLE: begin
          if (fifo_read_enb) state <= HDR_WAIT;
        end
        HDR_WAIT: begin
          if (arrive) begin
            hdr_addr   <=
              fifo_data[ADDR_MSB:ADDR_LSB];
            parity_acc <= fifo_data;
            remaining  <= pkt_remaining(fifo_data);
            state      <= BODY;
          end
        end
        BODY: begin
          if (fifo_read_enb)
            remaining <= remaining - 7'd1;
          if (arrive && pend_last)
            state <= DRAIN;
          else if (arrive)
            parity_acc <= parity_acc ^ fifo_data;
        end
        DRAIN: begin
          if (drain_ok)
            state <= fifo_read_enb ? HDR_WAIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  router_out_skid u_skid (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (xfer),
    .flush (timeout),
    .din   (push_ent),
    .count (skid_cnt),
    .head  (head)
  );

  assign vld_out    = skid_cnt != 2'd0;
  assign data_out   = head.data;
  assign sop_out    = head.sop;
  assign eop_out    = head.eop;
  assign parity_err = head.perr;
  assign busy       = (state != IDLE) || vld_out;

endmodule

// File: tb/tb_router_out_ctrl.sv
// Directed bench for router_out_ctrl with a
// behavioural router_fifo on the read side.
module tb_router_out_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       ready_in = 1'b0;
  logic       fifo_read_enb;
  logic       soft_reset_out;
  logic       vld_out;
  logic [7:0] data_out;
  logic       sop_out;
  logic       eop_out;
  logic       parity_err;
  logic [1:0] hdr_addr;
  logic       busy;

  router_out_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .fifo_read_enb  (fifo_read_enb),
    .soft_reset_out (soft_reset_out),
    .ready_in       (ready_in),
    .vld_out        (vld_out),
    .data_out       (data_out),
    .sop_out        (sop_out),
    .eop_out        (eop_out),
    .parity_err     (parity_err),
    .hdr_addr       (hdr_addr),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] hdr;
    logic       bad_par;
    int         rmode;
    int         exp_len;
    logic       exp_perr;
    logic [1:0] exp_addr;
    logic       chk_rate;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  fq[$];
  logic [7:0]  pk[$];
  logic [7:0]  pay[64];
  logic [10:0] got[$];
  int          got_cyc[$];
  logic [1:0]  got_addr = 2'b00;
  logic        seen_eop = 1'b0;
  logic        rd_s = 1'b0;
  logic        sr_s = 1'b0;
  int          cyc = 0;
  int          occ = 0;
  int          occ_max = 0;
  int          sr_cnt = 0;

  // Output monitor and occupancy tracker.
  always @(negedge clock) begin
    cyc++;
    rd_s = fifo_read_enb;
    sr_s = soft_reset_out;
    if (sr_s) sr_cnt++;
    if (vld_out && ready_in) begin
      got.push_back({parity_err, eop_out,
                     sop_out, data_out});
      got_cyc.push_back(cyc);
      if (eop_out) begin
        got_addr = hdr_addr;
        seen_eop = 1'b1;
      end
    end
    occ = occ + int'(fifo_read_enb)
        - int'(vld_out && ready_in);
    if (occ > occ_max) occ_max = occ;
  end

  // router_fifo model: one-cycle read latency.
  always @(posedge clock) begin
    #2;
    if (sr_s)
      fq.delete();
    else if (rd_s && fq.size() > 0)
      fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic build(input logic [7:0] hdr,
                       input logic bad);
    logic [7:0] par;
    pk.delete();
    pk.push_back(hdr);
    par = hdr;
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      pk.push_back(pay[i]);
      par ^= pay[i];
    end
    pk.push_back(bad ? (par ^ 8'h01) : par);
  endtask

  task automatic load();
    @(posedge clock);
    #1;
    foreach (pk[i]) fq.push_back(pk[i]);
    fifo_empty = 1'b0;
  endtask

  task automatic run_pkt(input vec_t v,
                         input string tag);
    int t;
    int n;
    int last;
    logic [10:0] exp;
    build(v.hdr, v.bad_par);
    got.delete();
    got_cyc.delete();
    seen_eop = 1'b0;
    occ = 0;
    occ_max = 0;
    load();
    t = 0;
    while (!seen_eop && t < 3000) begin
      if (v.rmode == 0)
        ready_in = 1'b1;
      else if (v.rmode == 1)
        ready_in = t[0];
      else
        ready_in = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      t++;
    end
    ready_in = 1'b1;
    check({tag, "_eop_seen"},
          32'(seen_eop), 32'd1);
    check({tag, "_len"},
          32'(got.size()), 32'(v.exp_len));
    last = pk.size() - 1;
    n = (got.size() < pk.size()) ?
        got.size() : pk.size();
    for (int i = 0; i < n; i++) begin
      exp = {(i == last) && v.exp_perr,
             i == last, i == 0, pk[i]};
      check($sformatf("%s_byte%0d", tag, i),
            32'(got[i]), 32'(exp));
    end
    check({tag, "_addr"},
          32'(got_addr), 32'(v.exp_addr));
    check({tag, "_occ_le2"},
          32'(occ_max <= 2), 32'd1);
    if (v.chk_rate && got.size() >= 2)
      check({tag, "_rate"},
            32'(got_cyc[got.size() - 1] -
                got_cyc[1]),
            32'(v.exp_len - 2));
    repeat (2) @(negedge clock);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  vec_t vt[6];

  initial begin
    int stall;
    int sr_at;
    int t;

    vt[0] = '{8'h39, 1'b0, 0, 16, 1'b0, 2'b01, 1'b1};
    vt[1] = '{8'h39, 1'b0, 1, 16, 1'b0, 2'b01, 1'b0};
    vt[2] = '{8'h02, 1'b0, 0,  2, 1'b0, 2'b10, 1'b0};
    vt[3] = '{8'h39, 1'b1, 0, 16, 1'b1, 2'b01, 1'b0};
    vt[4] = '{8'hFF, 1'b0, 2, 65, 1'b0, 2'b11, 1'b0};
    vt[5] = '{8'h0D, 1'b0, 0,  5, 1'b0, 2'b01, 1'b1};
    foreach (pay[i]) pay[i] = 8'($urandom);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outs",
          32'({vld_out, sop_out, eop_out,
               parity_err, soft_reset_out,
               fifo_read_enb, busy, hdr_addr,
               data_out}), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int k = 0; k < 5; k++)
      run_pkt(vt[k], $sformatf("vec%0d", k));

    // Destination stalls after the header.
    build(8'h39, 1'b0);
    got.delete();
    sr_cnt = 0;
    ready_in = 1'b0;
    load();
    stall = 0;
    sr_at = 0;
    for (int c = 0; c < 200 && sr_at == 0; c++) begin
      @(negedge clock);
      if (vld_out && !ready_in) stall++;
      if (soft_reset_out) sr_at = stall;
    end
    check("to_stall_cycle", 32'(sr_at), 32'd30);
    @(negedge clock);
    check("to_vld_after", 32'(vld_out), 32'd0);
    check("to_busy_after", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    check("to_pulse_once", 32'(sr_cnt), 32'd1);
    check("to_no_xfer", 32'(got.size()), 32'd0);
    run_pkt(vt[2], "after_to");

    // Reset in the middle of the payload.
    build(8'h39, 1'b0);
    got.delete();
    ready_in = 1'b1;
    load();
    t = 0;
    while (got.size() < 6 && t < 200) begin
      @(posedge clock);
      #1;
      t++;
    end
    check("rst_reached_b5", 32'(got.size() >= 6),
          32'd1);
    reset = 1'b1;
    fq.delete();
    fifo_empty = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst_mid_outs",
          32'({vld_out, sop_out, eop_out,
               parity_err, soft_reset_out,
               fifo_read_enb, busy, hdr_addr,
               data_out}), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_pkt(vt[5], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
